dircc_dual_port_processing_mem: RTL
===================================

# dircc_dual_port_processing_mem

Parametrised, true dual-port on-chip processing memory for DiRCC nodes. It generalises the fixed 32/16-bit node memory with configurable word width, width ratio, depth and optional output register. It adds readdatavalid pipelining, per-port waitrequest, deterministic same-byte write-collision resolution and a hardware clear engine that zeroes the array after reset or on request. Port A is the Nios data master side (s1); port B is the narrow fabric/NoC side (s2).

## Interface
- DATA_WIDTH_A, 32, port A word width in bits; multiple of 8
- WIDTH_RATIO, 2, port A width / port B width; one of 1, 2, 4
- DEPTH_A, 10240, port A words; port B depth = DEPTH_A*WIDTH_RATIO
- ADDR_WIDTH_A, 14, port A address width; ceil(log2(DEPTH_A)) or more
- ADDR_WIDTH_B, 15, port B address width; ceil(log2(DEPTH_A*WIDTH_RATIO)) or more
- OUTPUT_REG, 0, 1 adds a registered output stage on both ports
- CLEAR_ON_RESET, 1, 1 runs the clear engine automatically on reset release
- clk  in  1  single clock for both ports and all logic
- reset  in  1  asynchronous, active-high
- reset_req  in  1  when high, freezes all state: no accesses, clear counter and pipelines hold
- clear_req  in  1  one-cycle pulse starts a clear; ignored while clearing
- clear_busy  out  1  high while the clear engine runs
- address / address2  in  ADDR_WIDTH_A / ADDR_WIDTH_B  word addresses
- byteenable / byteenable2  in  DATA_WIDTH_A/8 / DATA_WIDTH_A/8/WIDTH_RATIO  byte lanes
- chipselect, write, clken / chipselect2, write2, clken2  in  1 each  per-port request and clock enable
- writedata / writedata2  in  DATA_WIDTH_A / DATA_WIDTH_A/WIDTH_RATIO  write data
- readdata / readdata2  out  same widths  read data
- readdatavalid / readdatavalid2  out  1  read data qualifier
- waitrequest / waitrequest2  out  1  request not accepted this cycle

## Operation
- Mapping: port B word k equals port A word k/WIDTH_RATIO, lane k%WIDTH_RATIO. Lane 0 holds the least-significant bits.
- Port A accepts a request when chipselect & clken & ~waitrequest & ~reset_req. Port B uses its own signals with the same rule.
- An accepted write updates only the enabled bytes. An accepted read (write=0) enters the read pipeline.
- A cycle with clken=0 stalls that port: its read pipeline, readdata and readdatavalid hold.
- Same-port read-during-write cannot occur, because a request is either a read or a write.
- Mixed-port read-during-write to the same byte returns OLD_DATA.
- Write collision: if both ports write the same byte in the same cycle, port A's value is stored. Non-overlapping bytes from both ports are written.
- Out-of-range address (at or above the port depth): the write is dropped; the read returns 0 and still produces readdatavalid.
- Clear FSM states:
  - IDLE → CLEAR on reset release when CLEAR_ON_RESET=1, or on clear_req.
  - CLEAR writes zero to A-word cnt, with cnt running 0..DEPTH_A-1, one word per cycle in which reset_req=0. The FSM ignores clken.
  - CLEAR → IDLE after writing word DEPTH_A-1.
- In CLEAR: clear_busy=1 and both waitrequests are 1.
- Reads already accepted before CLEAR began complete normally.
- Reset asserted mid-clear aborts the clear; the counter returns to 0. Array contents are not reset.
- Reset values:
  - readdata, readdata2: 0.
  - readdatavalid, readdatavalid2: 0.
  - clear_busy: 1 if CLEAR_ON_RESET, else 0.
  - waitrequest, waitrequest2: 1 if CLEAR_ON_RESET, else 0.

## Timing
- Read latency is L = 1 + OUTPUT_REG enabled (clken=1) cycles from acceptance to readdatavalid=1 with data.
- readdatavalid is a one-cycle pulse per accepted read, subject to clken stall.
- Back-to-back reads are accepted every cycle: throughput is 1 per port per cycle.
- A write is visible to a read accepted on either port in the next cycle.
- Clear takes exactly DEPTH_A cycles with reset_req=0. clear_busy falls the cycle after the last zero write, and requests are accepted that same cycle.
- reset_req high for N cycles extends the clear by N cycles.

## Test plan
- Mixed width: write A[5]=0xAABBCCDD with byteenable=0xF, then read B[10] and B[11] → 0xCCDD and 0xAABB, each with readdatavalid at latency L.
- Collision: in the same cycle, A writes word 3 = 0x11111111 with byteenable=0x3 and B writes word 6 = 0x2222 with byteenable2=0x3; read A[3] → 0x00001111. Then repeat with B writing word 7 = 0x3333: read → 0x33331111.
- Mixed read-during-write: A[0]=0x1. Same cycle, B writes word 0 = 0xFFFF and A reads word 0 → 0x00000001. The next A read → 0x0000FFFF.
- Clear: DEPTH_A=16. Fill all words with 0xFFFFFFFF, pulse clear_req → waitrequest high for 16 cycles, then all reads return 0. Assert reset at cycle 8 of the clear → the clear restarts and finishes 16 cycles after reset release.
- Stall/freeze: hold clken=0 for 3 cycles after a read is accepted → readdatavalid is delayed by 3 cycles with data intact. Hold reset_req=1 for 4 cycles during a clear → clear_busy lasts DEPTH_A+4 cycles.
- Out of range: read A[DEPTH_A] → readdatavalid with readdata=0. A write to B[2*DEPTH_A] leaves the memory unchanged.

Source files
------------

// File: rtl/dircc_dual_port_processing_mem.sv
// rtl/dircc_dual_port_processing_mem.sv - DiRCC true dual-port processing memory with mixed widths and clear engine
module dircc_dual_port_processing_mem #(
  parameter int DATA_WIDTH_A   = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int DEPTH_A        = 10240,
  parameter int ADDR_WIDTH_A   = 14,
  parameter int ADDR_WIDTH_B   = 15,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      reset_req,
  input  logic                                      clear_req,
  output logic                                      clear_busy,
  input  logic [ADDR_WIDTH_A-1:0]                   address,
  input  logic [DATA_WIDTH_A/8-1:0]                 byteenable,
  input  logic                                      chipselect,
  input  logic                                      write,
  input  logic                                      clken,
  input  logic [DATA_WIDTH_A-1:0]                   writedata,
  output logic [DATA_WIDTH_A-1:0]                   readdata,
  output logic                                      readdatavalid,
  output logic                                      waitrequest,
  input  logic [ADDR_WIDTH_B-1:0]                   address2,
  input  logic [DATA_WIDTH_A/8/WIDTH_RATIO-1:0]     byteenable2,
  input  logic                                      chipselect2,
  input  logic                                      write2,
  input  logic                                      clken2,
  input  logic [DATA_WIDTH_A/WIDTH_RATIO-1:0]       writedata2,
  output logic [DATA_WIDTH_A/WIDTH_RATIO-1:0]       readdata2,
  output logic                                      readdatavalid2,
  output logic                                      waitrequest2
);

  localparam int NB    = DATA_WIDTH_A / 8;
  localparam int DW_B  = DATA_WIDTH_A / WIDTH_RATIO;
  localparam int NB_B  = NB / WIDTH_RATIO;
  localparam int LOG_R = (WIDTH_RATIO == 4) ? 2 : (WIDTH_RATIO == 2) ? 1 : 0;
  localparam int IDX_W = (DEPTH_A > 1) ? $clog2(DEPTH_A) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [DATA_WIDTH_A-1:0] mem [DEPTH_A];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               vld1_a_q, vld1_a_d, vld2_a_q, vld2_a_d;
  logic               vld1_b_q, vld1_b_d, vld2_b_q, vld2_b_d;
  logic [DATA_WIDTH_A-1:0] dat1_a_q, dat1_a_d, dat2_a_q, dat2_a_d;
  logic [DW_B-1:0]    dat1_b_q, dat1_b_d, dat2_b_q, dat2_b_d;

  logic [IDX_W-1:0]   idx_a, idx_b;
  logic [1:0]         lane_b;
  logic               in_a, in_b, acc_a, acc_b, rd_a, rd_b, en_a, en_b, clr_we;
  logic [NB-1:0]      we_a, we_b;
  logic [DATA_WIDTH_A-1:0] wd_b, rdata_a, rword_b;
  logic [DW_B-1:0]    rdata_b;

  // Port B word k lives in A word k>>LOG_R, lane k%R, lane 0 at the LSBs
  always_comb begin
    idx_a  = IDX_W'(address);
    in_a   = 32'(address) < 32'(DEPTH_A);
    idx_b  = IDX_W'(address2 >> LOG_R);
    lane_b = 2'(address2 & ADDR_WIDTH_B'(WIDTH_RATIO - 1));
    in_b   = 32'(address2) < 32'(DEPTH_A * WIDTH_RATIO);
    wd_b   = {WIDTH_RATIO{writedata2}};

    clear_busy   = (state_q == CLEAR);
    waitrequest  = clear_busy;
    waitrequest2 = clear_busy;
    clr_we       = clear_busy & ~reset_req;

    acc_a = chipselect  & clken  & ~waitrequest  & ~reset_req;
    acc_b = chipselect2 & clken2 & ~waitrequest2 & ~reset_req;
    rd_a  = acc_a & ~write;
    rd_b  = acc_b & ~write2;
    en_a  = clken  & ~reset_req;
    en_b  = clken2 & ~reset_req;

    we_a = '0;
    we_b = '0;
    for (int i = 0; i < NB; i++) begin
      we_a[i] = acc_a & write & in_a & byteenable[i];
      we_b[i] = acc_b & write2 & in_b & ((i / NB_B) == int'(lane_b)) & byteenable2[i % NB_B];
    end

    rdata_a = in_a ? mem[idx_a] : '0;
    rword_b = mem[idx_b];
    rdata_b = in_b ? rword_b[int'(lane_b)*DW_B +: DW_B] : '0;
  end

  // Port A is written after port B so it wins any same-byte collision
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we_b[i]) mem[idx_b][8*i +: 8] <= wd_b[8*i +: 8];
        if (we_a[i]) mem[idx_a][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!reset_req) begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          if (cnt_q == IDX_W'(DEPTH_A - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vld1_a_d = vld1_a_q;
    dat1_a_d = dat1_a_q;
    vld2_a_d = vld2_a_q;
    dat2_a_d = dat2_a_q;
    if (en_a) begin
      vld1_a_d = rd_a;
      if (rd_a) dat1_a_d = rdata_a;
      vld2_a_d = vld1_a_q;
      if (vld1_a_q) dat2_a_d = dat1_a_q;
    end
    vld1_b_d = vld1_b_q;
    dat1_b_d = dat1_b_q;
    vld2_b_d = vld2_b_q;
    dat2_b_d = dat2_b_q;
    if (en_b) begin
      vld1_b_d = rd_b;
      if (rd_b) dat1_b_d = rdata_b;
      vld2_b_d = vld1_b_q;
      if (vld1_b_q) dat2_b_d = dat1_b_q;
    end
    readdata       = (OUTPUT_REG != 0) ? dat2_a_q : dat1_a_q;
    readdatavalid  = (OUTPUT_REG != 0) ? vld2_a_q : vld1_a_q;
    readdata2      = (OUTPUT_REG != 0) ? dat2_b_q : dat1_b_q;
    readdatavalid2 = (OUTPUT_REG != 0) ? vld2_b_q : vld1_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      vld1_a_q <= 1'b0;
      vld2_a_q <= 1'b0;
      dat1_a_q <= '0;
      dat2_a_q <= '0;
      vld1_b_q <= 1'b0;
      vld2_b_q <= 1'b0;
      dat1_b_q <= '0;
      dat2_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld1_a_q <= vld1_a_d;
      vld2_a_q <= vld2_a_d;
      dat1_a_q <= dat1_a_d;
      dat2_a_q <= dat2_a_d;
      vld1_b_q <= vld1_b_d;
      vld2_b_q <= vld2_b_d;
      dat1_b_q <= dat1_b_d;
      dat2_b_q <= dat2_b_d;
    end
  end

endmodule
